// File: rtl/seq_pkg.sv
// Shared definitions for the counter-chain sequencer: command opcodes,
// FSM states and the default chain width.
package seq_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_LOAD     = 2'b00,
        OP_UP_N     = 2'b01,
        OP_DOWN_N   = 2'b10,
        OP_UP_TO_TC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/seq_step_counter.sv
// Remaining-step down-counter: loads a step count, decrements on request
// and flags when exactly one step is left.
module seq_step_counter
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_dec,
    output logic             o_is_one
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_is_one = (r_count == WIDTH'(1));

endmodule

// File: rtl/ttl74x169.sv
// Behavioural model of one 4-bit synchronous up/down binary counter slice
// (74x169). Like the real part it has no reset.
module ttl74x169 (
    input  logic       i_clk,
    input  logic       i_load_n,
    input  logic       i_ud,
    input  logic       i_ent_n,
    input  logic       i_enp_n,
    input  logic [3:0] i_d,
    output logic [3:0] o_q,
    output logic       o_rco_n
);

    logic [3:0] r_q;

    always_ff @(posedge i_clk) begin
        if (!i_load_n) begin
            r_q <= i_d;
        end else if (!i_ent_n && !i_enp_n) begin
            r_q <= i_ud ? r_q + 4'd1 : r_q - 4'd1;
        end
    end

    // Ripple carry is gated by ent only, so it propagates through a cascade.
    assign o_rco_n = !(!i_ent_n && (i_ud ? (r_q == 4'hF) : (r_q == 4'h0)));
    assign o_q     = r_q;

endmodule

// File: rtl/count_sequencer.sv
// Command sequencer driving a cascaded 74x169 counter chain: load, count
// up/down by N, or count up to terminal count.
module count_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             busy,
    output logic             done,
    output logic             wrapped,
    output logic             ctr_load_n,
    output logic             ctr_ud,
    output logic             ctr_ent_n,
    output logic             ctr_enp_n,
    output logic [WIDTH-1:0] ctr_d,
    input  logic             ctr_rco_n
);

    state_e           r_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_data;
    logic             r_wrapped;

    logic             w_accept;
    logic             w_is_one;
    logic             w_step_dec;
    logic             w_run_exit;
    op_e              w_cmd_op;

    assign w_cmd_op   = op_e'(cmd_op);
    assign w_accept   = cmd_valid && (r_state == ST_IDLE);
    assign w_step_dec = (r_state == ST_RUN) && (r_op != OP_UP_TO_TC);
    assign w_run_exit = (r_op == OP_UP_TO_TC) ? !ctr_rco_n : w_is_one;

    seq_step_counter #(
        .WIDTH (WIDTH)
    ) u_step_counter (
        .i_clk    (clock),
        .i_rst    (reset),
        .i_load   (w_accept),
        .i_value  (cmd_data),
        .i_dec    (w_step_dec),
        .o_is_one (w_is_one)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_LOAD;
            r_data    <= '0;
            r_wrapped <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op      <= w_cmd_op;
                        r_data    <= cmd_data;
                        r_wrapped <= 1'b0;
                        if (w_cmd_op == OP_LOAD) begin
                            r_state <= ST_LOAD;
                        end else if ((w_cmd_op == OP_UP_TO_TC) || (cmd_data != '0)) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_LOAD: r_state <= ST_DONE;
                ST_RUN: begin
                    if (!ctr_rco_n) begin
                        r_wrapped <= 1'b1;
                    end
                    if (w_run_exit) begin
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Chain controls are a pure decode of registered state.
    always_comb begin
        cmd_ready  = (r_state == ST_IDLE);
        busy       = (r_state != ST_IDLE);
        done       = (r_state == ST_DONE);
        wrapped    = r_wrapped;
        ctr_load_n = 1'b1;
        ctr_ent_n  = 1'b1;
        ctr_enp_n  = 1'b1;
        ctr_ud     = 1'b1;
        ctr_d      = '0;
        case (r_state)
            ST_LOAD: begin
                ctr_load_n = 1'b0;
                ctr_d      = r_data;
            end
            ST_RUN: begin
                ctr_ent_n = 1'b0;
                ctr_enp_n = 1'b0;
                ctr_ud    = (r_op != OP_DOWN_N);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench: count_sequencer driving a four-slice 74x169 chain, checked against
// an arithmetic model of chain value, wrap flag and command timing.
module tb_count_sequencer;
    import seq_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        busy, done, wrapped;
    logic        ctr_load_n, ctr_ud, ctr_ent_n, ctr_enp_n;
    logic [15:0] ctr_d;
    logic        ctr_rco_n;

    logic [3:0]  w_q0, w_q1, w_q2, w_q3;
    logic        w_c1, w_c2, w_c3;
    logic [15:0] chain_q;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned m_q     = 0;

    always #5 clock = ~clock;

    count_sequencer #(.WIDTH(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .busy       (busy),
        .done       (done),
        .wrapped    (wrapped),
        .ctr_load_n (ctr_load_n),
        .ctr_ud     (ctr_ud),
        .ctr_ent_n  (ctr_ent_n),
        .ctr_enp_n  (ctr_enp_n),
        .ctr_d      (ctr_d),
        .ctr_rco_n  (ctr_rco_n)
    );

    ttl74x169 u_s0 (.i_clk(clock), .i_load_n(ctr_load_n), .i_ud(ctr_ud), .i_ent_n(ctr_ent_n),
                    .i_enp_n(ctr_enp_n), .i_d(ctr_d[3:0]),   .o_q(w_q0), .o_rco_n(w_c1));
    ttl74x169 u_s1 (.i_clk(clock), .i_load_n(ctr_load_n), .i_ud(ctr_ud), .i_ent_n(w_c1),
                    .i_enp_n(ctr_enp_n), .i_d(ctr_d[7:4]),   .o_q(w_q1), .o_rco_n(w_c2));
    ttl74x169 u_s2 (.i_clk(clock), .i_load_n(ctr_load_n), .i_ud(ctr_ud), .i_ent_n(w_c2),
                    .i_enp_n(ctr_enp_n), .i_d(ctr_d[11:8]),  .o_q(w_q2), .o_rco_n(w_c3));
    ttl74x169 u_s3 (.i_clk(clock), .i_load_n(ctr_load_n), .i_ud(ctr_ud), .i_ent_n(w_c3),
                    .i_enp_n(ctr_enp_n), .i_d(ctr_d[15:12]), .o_q(w_q3), .o_rco_n(ctr_rco_n));

    assign chain_q = {w_q3, w_q2, w_q1, w_q0};

    // Expected outcome of one command from the chain value it starts on.
    // lat = sampled cycles after the accepting edge until done is seen.
    task automatic model_cmd(input logic [1:0] op, input int unsigned data, input int unsigned q_in,
                             output int unsigned q_out, output bit wr, output int run, output int lat);
        case (op)
            2'b00: begin q_out = data; wr = 1'b0; run = 0; lat = 2; end
            2'b01: begin
                q_out = (q_in + data) % 65536;
                wr    = (q_in + data) > 65535;
                run   = int'(data);
                lat   = int'(data) + 1;
            end
            2'b10: begin
                q_out = (q_in + 65536 - data) % 65536;
                wr    = data > q_in;
                run   = int'(data);
                lat   = int'(data) + 1;
            end
            default: begin
                run   = int'(65536 - q_in);
                q_out = 0;
                wr    = 1'b1;
                lat   = run + 1;
            end
        endcase
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [15:0] data, input bit spam,
                             output int lat, output int en_cyc, output int ld_cyc, output int ud_bad,
                             output int ready_bad, output logic [15:0] d_seen, output bit wr_seen,
                             output bit pulse_ok);
        int  k;
        bit  exp_ud;
        exp_ud    = (op != 2'b10);
        lat       = -1;
        en_cyc    = 0;
        ld_cyc    = 0;
        ud_bad    = 0;
        ready_bad = 0;
        d_seen    = '0;
        wr_seen   = 1'b0;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 100) begin
            @(posedge clock); #1;
            k++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clock); #1;
        cmd_valid = spam;
        for (int c = 1; c <= 200; c++) begin
            if (cmd_ready !== 1'b0 || busy !== 1'b1) ready_bad++;
            if (ctr_load_n === 1'b0) begin ld_cyc++; d_seen = ctr_d; end
            if (ctr_ent_n === 1'b0 && ctr_enp_n === 1'b0) begin
                en_cyc++;
                if (ctr_ud !== exp_ud) ud_bad++;
            end
            if (done === 1'b1) begin
                lat     = c;
                wr_seen = wrapped;
                break;
            end
            if (spam) begin
                cmd_op   = 2'($urandom);
                cmd_data = 16'($urandom);
            end
            @(posedge clock); #1;
        end
        cmd_valid = 1'b0;
        @(posedge clock); #1;
        pulse_ok = (done === 1'b0) && (cmd_ready === 1'b1) && (busy === 1'b0);
    endtask

    task automatic test_command(input string name, input logic [1:0] op, input logic [15:0] data,
                                input bit spam);
        int unsigned q_exp;
        bit          wr_exp, wr_seen, pulse_ok;
        int          run_exp, lat_exp, lat, en_cyc, ld_cyc, ud_bad, ready_bad;
        logic [15:0] d_seen;
        model_cmd(op, int'(data), m_q, q_exp, wr_exp, run_exp, lat_exp);
        issue_cmd(op, data, spam, lat, en_cyc, ld_cyc, ud_bad, ready_bad, d_seen, wr_seen, pulse_ok);
        n_tests++;
        if (lat !== lat_exp) begin
            n_fail++;
            $display("FAIL %s done latency: got %0d expected %0d", name, lat, lat_exp);
        end
        n_tests++;
        if (en_cyc !== run_exp) begin
            n_fail++;
            $display("FAIL %s enable cycles: got %0d expected %0d", name, en_cyc, run_exp);
        end
        n_tests++;
        if (ld_cyc !== ((op == 2'b00) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s load cycles: got %0d expected %0d", name, ld_cyc, (op == 2'b00) ? 1 : 0);
        end
        n_tests++;
        if (ud_bad !== 0 || ready_bad !== 0) begin
            n_fail++;
            $display("FAIL %s ud/ready while busy: got %0d/%0d bad cycles expected 0/0", name, ud_bad, ready_bad);
        end
        n_tests++;
        if (wr_seen !== wr_exp) begin
            n_fail++;
            $display("FAIL %s wrapped: got %0b expected %0b", name, wr_seen, wr_exp);
        end
        n_tests++;
        if (pulse_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done pulse/return to idle: got done=%b ready=%b expected done=0 ready=1", name, done, cmd_ready);
        end
        n_tests++;
        if (chain_q !== 16'(q_exp)) begin
            n_fail++;
            $display("FAIL %s chain q: got %h expected %h", name, chain_q, 16'(q_exp));
        end
        if (op == 2'b00) begin
            n_tests++;
            if (d_seen !== data) begin
                n_fail++;
                $display("FAIL %s ctr_d during load: got %h expected %h", name, d_seen, data);
            end
        end
        m_q = q_exp;
    endtask

    task automatic check_idle(input string name);
        n_tests++;
        if ({cmd_ready, busy, done, wrapped, ctr_load_n, ctr_ent_n, ctr_enp_n, ctr_ud, ctr_d}
            !== {8'b1000_1111, 16'h0000}) begin
            n_fail++;
            $display("FAIL %s idle outputs: got rdy=%b busy=%b done=%b wr=%b ld_n=%b ent_n=%b enp_n=%b ud=%b d=%h expected 1 0 0 0 1 1 1 1 0000",
                     name, cmd_ready, busy, done, wrapped, ctr_load_n, ctr_ent_n, ctr_enp_n, ctr_ud, ctr_d);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_data = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check_idle("reset");
    endtask

    task automatic test_reset_mid_run();
        test_command("mid_run_preload", 2'b00, 16'h0100, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_data  = 16'd10;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        n_tests++;
        if (busy !== 1'b1 || ctr_ent_n !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run busy before reset: got busy=%b ent_n=%b expected 1 0", busy, ctr_ent_n);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_idle("mid_run_reset");
        n_tests++;
        if (chain_q !== 16'h0103) begin
            n_fail++;
            $display("FAIL mid_run chain q: got %h expected 0103", chain_q);
        end
        repeat (3) @(posedge clock);
        #1;
        n_tests++;
        if (chain_q !== 16'h0103) begin
            n_fail++;
            $display("FAIL mid_run chain held: got %h expected 0103", chain_q);
        end
        m_q = 32'h0103;
    endtask

    task automatic test_reset_with_valid();
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 16'hABCD;
        @(posedge clock); #1;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        check_idle("reset_with_valid");
        @(posedge clock); #1;
        n_tests++;
        if (chain_q !== 16'(m_q)) begin
            n_fail++;
            $display("FAIL reset_with_valid chain q: got %h expected %h", chain_q, 16'(m_q));
        end
    endtask

    task automatic test_back_to_back();
        test_command("b2b_load", 2'b00, 16'h7FFE, 1'b0);
        test_command("b2b_up", 2'b01, 16'd4, 1'b0);
        test_command("b2b_down", 2'b10, 16'd2, 1'b0);
    endtask

    task automatic test_busy_ignored();
        test_command("busy_load", 2'b00, 16'h0FF0, 1'b1);
        test_command("busy_up", 2'b01, 16'd7, 1'b1);
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [15:0] data;
        for (int i = 0; i < 25; i++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'b11) begin
                test_command("rand_pre_tc", 2'b00, 16'hFFFF - 16'($urandom_range(0, 15)), 1'b0);
            end else if (op != 2'b00 && $urandom_range(0, 1) == 1) begin
                data = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 8))
                                                   : 16'hFFFF - 16'($urandom_range(0, 8));
                test_command("rand_pre_edge", 2'b00, data, 1'b0);
            end
            data = (op == 2'b00) ? 16'($urandom) : 16'($urandom_range(0, 20));
            test_command("rand_cmd", op, data, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_command("load_1234", 2'b00, 16'h1234, 1'b0);
        test_command("pre_up", 2'b00, 16'h0005, 1'b0);
        test_command("up_n_3", 2'b01, 16'd3, 1'b0);
        test_command("pre_down", 2'b00, 16'h0001, 1'b0);
        test_command("down_n_3", 2'b10, 16'd3, 1'b0);
        test_command("pre_tc", 2'b00, 16'hFFFC, 1'b0);
        test_command("up_to_tc", 2'b11, 16'h5A5A, 1'b0);
        test_command("up_n_0", 2'b01, 16'd0, 1'b0);
        test_command("down_n_0", 2'b10, 16'd0, 1'b0);
        test_reset_mid_run();
        test_reset_with_valid();
        test_back_to_back();
        test_busy_ignored();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
